// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: valid/ready stream carrying a data word and a sideband vector
interface pipe_stage_chain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_WIDTH   = 2
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [SB_WIDTH-1:0]   sb;
  modport master (output valid, data, sb, input ready);
  modport slave  (input valid, data, sb, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic DEPTH-stage register pipeline with flush, occupancy and bubble-collapse/global-stall modes
module pipe_stage_chain #(
  parameter int DATA_WIDTH      = 8,
  parameter int SB_WIDTH        = 2,
  parameter int DEPTH           = 2,
  parameter int BUBBLE_COLLAPSE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  pipe_stage_chain_if.slave            in_if,
  pipe_stage_chain_if.master           out_if,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0]      valid, valid_nxt, src_valid, ready, load;
  logic [DATA_WIDTH-1:0] data [DEPTH];
  logic [DATA_WIDTH-1:0] src_data [DEPTH];
  logic [SB_WIDTH-1:0]   sb [DEPTH];
  logic [SB_WIDTH-1:0]   src_sb [DEPTH];
  logic                  adv, chain;
  // chain walks from the output end so each stage sees whether any slot ahead can make room
  always_comb begin
    adv         = out_if.ready || !valid[DEPTH-1];
    chain       = out_if.ready;
    ready       = '0;
    src_valid   = DEPTH'({valid, in_if.valid});
    src_data[0] = in_if.data;
    src_sb[0]   = in_if.sb;
    for (int i = 1; i < DEPTH; i++) begin
      src_data[i] = data[i-1];
      src_sb[i]   = sb[i-1];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain    = chain || !valid[i];
      ready[i] = (BUBBLE_COLLAPSE != 0) ? chain : adv;
    end
    load      = ready & src_valid & {DEPTH{!clear}};
    valid_nxt = clear ? '0 : (ready & src_valid) | (~ready & valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
        sb[i]   <= '0;
      end
    end else begin
      valid     <= valid_nxt;
      occupancy <= OW'($countones(valid_nxt));
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          data[i] <= src_data[i];
          sb[i]   <= src_sb[i];
        end
      end
    end
  end
  assign in_if.ready  = ready[0] && !clear;
  assign out_if.valid = valid[DEPTH-1] && !clear;
  assign out_if.data  = data[DEPTH-1];
  assign out_if.sb    = sb[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: runs both flow-control modes side by side against a slot-level token model
module tb_pipe_stage_chain;
  localparam int D = 3;
  logic       clk, rst_n, clear, iv, ordy;
  logic [7:0] idata;
  logic [1:0] isb;
  logic [1:0] occ_c, occ_s;
  int         checks, errors;
  bit         acc_c;
  bit         mv [2][D];
  logic [7:0] md [2][D];
  logic [1:0] ms [2][D];

  pipe_stage_chain_if #(.DATA_WIDTH(8), .SB_WIDTH(2)) in_c ();
  pipe_stage_chain_if #(.DATA_WIDTH(8), .SB_WIDTH(2)) out_c ();
  pipe_stage_chain_if #(.DATA_WIDTH(8), .SB_WIDTH(2)) in_s ();
  pipe_stage_chain_if #(.DATA_WIDTH(8), .SB_WIDTH(2)) out_s ();

  assign in_c.valid  = iv;
  assign in_c.data   = idata;
  assign in_c.sb     = isb;
  assign out_c.ready = ordy;
  assign in_s.valid  = iv;
  assign in_s.data   = idata;
  assign in_s.sb     = isb;
  assign out_s.ready = ordy;

  pipe_stage_chain #(.DATA_WIDTH(8), .SB_WIDTH(2), .DEPTH(D), .BUBBLE_COLLAPSE(1)) u_col (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(in_c), .out_if(out_c), .occupancy(occ_c));
  pipe_stage_chain #(.DATA_WIDTH(8), .SB_WIDTH(2), .DEPTH(D), .BUBBLE_COLLAPSE(0)) u_stl (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(in_s), .out_if(out_s), .occupancy(occ_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < D; i++) begin
        mv[m][i] = 1'b0;
        md[m][i] = '0;
        ms[m][i] = '0;
      end
  endfunction

  function automatic int model_count(int m);
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mv[m][i]);
    return n;
  endfunction

  // a word can enter if some slot will be free: collapse mode uses any hole, stall mode only the head moving
  function automatic bit exp_ready(int m);
    if (clear) return 1'b0;
    if (m == 1) return ordy || model_count(1) < D;
    return ordy || !mv[0][D-1];
  endfunction

  function automatic void model_step(int m);
    bit take = exp_ready(m) && iv;
    if (clear) begin
      for (int i = 0; i < D; i++) mv[m][i] = 1'b0;
      return;
    end
    if (m == 1) begin
      if (mv[1][D-1] && ordy) mv[1][D-1] = 1'b0;
      for (int i = D - 2; i >= 0; i--)
        if (mv[1][i] && !mv[1][i+1]) begin
          mv[1][i+1] = 1'b1; md[1][i+1] = md[1][i]; ms[1][i+1] = ms[1][i];
          mv[1][i]   = 1'b0;
        end
    end else if (ordy || !mv[0][D-1]) begin
      for (int i = D - 1; i >= 1; i--) begin
        mv[0][i] = mv[0][i-1];
        if (mv[0][i-1]) begin md[0][i] = md[0][i-1]; ms[0][i] = ms[0][i-1]; end
      end
      mv[0][0] = 1'b0;
    end
    if (take) begin
      mv[m][0] = 1'b1; md[m][0] = idata; ms[m][0] = isb;
    end
  endfunction

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      logic       ir  = m == 1 ? in_c.ready : in_s.ready;
      logic       ov  = m == 1 ? out_c.valid : out_s.valid;
      logic [7:0] od  = m == 1 ? out_c.data : out_s.data;
      logic [1:0] osb = m == 1 ? out_c.sb : out_s.sb;
      logic [1:0] oc  = m == 1 ? occ_c : occ_s;
      bit         eov = mv[m][D-1] && !clear;
      string      t   = m == 1 ? "col" : "stl";
      check({t, "_in_ready"}, 32'(ir), 32'(exp_ready(m)));
      check({t, "_out_valid"}, 32'(ov), 32'(eov));
      check({t, "_occupancy"}, 32'(oc), 32'(model_count(m)));
      if (eov) begin
        check({t, "_out_data"}, 32'(od), 32'(md[m][D-1]));
        check({t, "_out_sb"}, 32'(osb), 32'(ms[m][D-1]));
      end
    end
  endtask

  task automatic step(bit v, logic [7:0] d, logic [1:0] s, bit r, bit c);
    iv = v; idata = d; isb = s; ordy = r; clear = c;
    @(negedge clk);
    compare_all();
    acc_c = exp_ready(1) && iv;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string t);
    check({t, "_col_valid"}, 32'(out_c.valid), 0);
    check({t, "_col_data"}, 32'(out_c.data), 0);
    check({t, "_col_sb"}, 32'(out_c.sb), 0);
    check({t, "_col_occ"}, 32'(occ_c), 0);
    check({t, "_col_in_ready"}, 32'(in_c.ready), 1);
    check({t, "_stl_valid"}, 32'(out_s.valid), 0);
    check({t, "_stl_data"}, 32'(out_s.data), 0);
    check({t, "_stl_occ"}, 32'(occ_s), 0);
    check({t, "_stl_in_ready"}, 32'(in_s.ready), 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; clear = 1'b0; iv = 1'b0; ordy = 1'b1; idata = '0; isb = '0;
    model_reset();
    #3 check_zero("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    // streaming: three back-to-back words, head visible after the third edge
    step(1, 8'h11, 0, 1, 0);
    step(1, 8'h22, 0, 1, 0);
    step(1, 8'h33, 0, 1, 0);
    iv = 1'b0; #1;
    check("stream_occ", 32'(occ_c), 3);
    check("stream_head", 32'(out_c.data), 32'h11);
    check("stream_valid", 32'(out_c.valid), 1);
    repeat (4) step(0, 0, 0, 1, 0);
    // backpressure fill: fourth push must be refused
    step(1, 8'h41, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0);
    step(1, 8'h43, 0, 0, 0);
    #1;
    check("full_in_ready", 32'(in_c.ready), 0);
    check("full_occ", 32'(occ_c), 3);
    step(1, 8'h44, 0, 0, 0);
    check("full_hold_data", 32'(out_c.data), 32'h41);
    repeat (4) step(0, 0, 0, 1, 0);
    // bubble collapse vs global stall
    step(1, 8'hA1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("bubble_col_occ", 32'(occ_c), 2);
    check("bubble_stl_occ", 32'(occ_s), 2);
    repeat (5) step(0, 0, 0, 1, 0);
    // clear collision on a full chain
    repeat (3) step(1, 8'h55, 1, 0, 0);
    iv = 1'b1; idata = 8'h55; ordy = 1'b1; clear = 1'b1; #1;
    check("clear_in_ready", 32'(in_c.ready), 0);
    check("clear_out_valid", 32'(out_c.valid), 0);
    step(1, 8'h55, 1, 1, 1);
    iv = 1'b0; clear = 1'b0; #1;
    check("clear_occ", 32'(occ_c), 0);
    check("clear_stl_occ", 32'(occ_s), 0);
    check("clear_out_valid_after", 32'(out_c.valid), 0);
    // async reset with two words in flight
    step(1, 8'h61, 2, 0, 0);
    step(1, 8'h62, 1, 0, 0);
    iv = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_c.ready), 1);
    // sideband done marker on the fourth word under random backpressure
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin
        step(1, 8'hC0 + 8'(k), k == 3 ? 2'b10 : 2'b00, 1'($urandom_range(0, 1)), 0);
        n++;
      end while (!acc_c && n < 50);
      if (!acc_c) check("sb_push_timeout", 32'(n), 0);
    end
    repeat (20) begin
      step(0, 0, 0, 1'($urandom_range(0, 1)), 0);
      if (out_c.valid && out_c.data[7:4] == 4'hC)
        check("sb_done", 32'(out_c.sb), out_c.data == 8'hC3 ? 32'd2 : 32'd0);
    end
    // random traffic with occasional flush
    repeat (400)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0);
    repeat (6) step(0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline of DEPTH register stages, each carrying a data word, a sideband vector (done, co_filter and similar) and a valid bit.
- Supersedes the fixed single-stage pipeline registers between datapath stages (loader → filter → accumulator).
- Adds valid/ready flow control, selectable bubble-collapsing or global-stall mode, synchronous flush, and an occupancy count.

Parameters:
- DATA_WIDTH, 8: payload width per stage.
- SB_WIDTH, 2: sideband width, e.g. {done, co_filter}. Must be ≥1.
- DEPTH, 2: number of register stages. Must be ≥1.
- BUBBLE_COLLAPSE, 1:
  - 1: each stage advances independently into an empty slot.
  - 0: all stages advance together or hold together (global stall).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous flush of all stages.
- in_valid, input, 1: upstream presents a word.
- in_ready, output, 1: chain accepts a word this cycle.
- in_data, input, DATA_WIDTH: payload in.
- in_sb, input, SB_WIDTH: sideband in.
- out_valid, output, 1: last stage holds a valid word.
- out_ready, input, 1: downstream accepts. Equivalent to !stall.
- out_data, output, DATA_WIDTH: last-stage payload.
- out_sb, output, SB_WIDTH: last-stage sideband.
- occupancy, output, $clog2(DEPTH+1): count of valid stages.

Behaviour:
- Reset (rst=0, asynchronous): all valid bits, data and sideband registers, and occupancy go to 0. Consequently out_valid=0, out_data=0, out_sb=0. in_ready reflects the empty chain (1) unless clear=1.
- Reset mid-transfer drops all in-flight words. No partial state survives.
- Stage 0 is the input end; stage DEPTH-1 drives the outputs directly (registered, no combinational path from in_* to out_*).
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- BUBBLE_COLLAPSE=1:
  - ready[DEPTH] = out_ready.
  - ready[i] = !valid[i] || ready[i+1].
  - in_ready = ready[0] && !clear.
  - Stage i loads from stage i-1 (or from the inputs for i=0) when ready[i]. It then sets valid[i] = valid[i-1] (in_valid for i=0).
  - The ready chain is combinational, DEPTH levels deep.
- BUBBLE_COLLAPSE=0:
  - adv = out_ready || !valid[DEPTH-1].
  - All stages shift together when adv. in_ready = adv && !clear.
  - Bubbles are carried through the chain, not squeezed out.
- Data and sideband registers are enabled only on load. Values in invalid stages are don't-care for the verification engineer, but the implementation must not toggle them when a stage holds.
- Latency: with out_ready held at 1, a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput: 1 word/cycle in both modes when out_ready=1.
- Full condition: all valid bits are 1 and out_ready=0. Then in_ready=0, contents hold, and out_data/out_sb stay stable.
- Empty condition: occupancy=0, out_valid=0.
- Order is strictly FIFO; no word is duplicated or lost except by clear or rst.
- Clear:
  - At the next edge all valid bits go to 0.
  - While clear=1: in_ready=0 and out_valid=0, i.e. out_valid = valid[DEPTH-1] && !clear. No transfer occurs at either end.
  - Clear wins over simultaneous in_valid and out_ready.
- Occupancy:
  - Registered; updated every edge as popcount of the next valid vector.
  - Simultaneous in and out transfer leaves it unchanged when the chain is full.
  - Never exceeds DEPTH.
- Sideband follows its data word exactly. A done pulse emerges in the same cycle as its word.

Test Plan:
- Streaming (DEPTH=3, out_ready=1): drive 0x11, 0x22, 0x33 on consecutive cycles → out_data shows 0x11, 0x22, 0x33 on cycles 3, 4, 5 with out_valid=1, and occupancy reaches 3.
- Backpressure fill (mode 1): out_ready=0, push 4 words → first 3 accepted, in_ready=0 on the 4th, occupancy=3. Releasing out_ready drains them in order with no gap.
- Bubble collapse vs global stall: send 0xA1, idle one cycle, then 0xA2, with out_ready=0 for 3 cycles.
  - Mode 1: both words held in adjacent stages, occupancy=2.
  - Mode 0: bubble preserved; 0xA2 emerges 2 cycles after 0xA1 once released.
- Clear collision: chain full with 0x55..., assert clear with in_valid=1 and out_ready=1 → in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0 and input 0x55 is not captured.
- Async reset mid-stream: drop rst between clock edges with 2 words in flight → outputs go to 0 immediately (before the next edge), occupancy=0, in_ready=1 after rst returns high.
- Sideband: in_sb=2'b10 (done) on the 4th of 4 words → out_sb=2'b10 exactly with the 4th out_data, under a random out_ready pattern.
